// File: rtl/security_pkg.sv
// security_pkg: definitions shared by the home security controller blocks.
//   - Command encodings driven on the controller's command bus.
//   - Keypad key codes with a special meaning.
//   - keypad_tx FSM state enum.
//   - key_to_cmd(): maps a command key to its command encoding.
package security_pkg;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_ARM    = 2'b01;
  localparam logic [1:0] CMD_DISARM = 2'b10;
  localparam logic [1:0] CMD_SET    = 2'b11;

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_SET    = 4'hC;
  localparam logic [3:0] KEY_CLEAR  = 4'hD;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CMD     = 2'd1,
    ST_DIGITS  = 2'd2,
    ST_DONE    = 2'd3
  } kp_state_e;

  function automatic logic [1:0] key_to_cmd(input logic [3:0] key);
    logic [1:0] cmd;
    cmd = CMD_NOP;
    case (key)
      KEY_ARM:    cmd = CMD_ARM;
      KEY_DISARM: cmd = CMD_DISARM;
      KEY_SET:    cmd = CMD_SET;
      default:    cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/keypad_tx_pin_buffer.sv
// pin_buffer: PIN_LEN x 4-bit register holding PIN digits in entry order.
// Ports:
//   clk, reset   clock, synchronous active-high reset (buffer empty)
//   push         append push_digit after the newest digit (ignored when full)
//   push_digit   digit to append
//   pop          drop the oldest digit (ignored when empty)
//   clear        empty the buffer; wins over push and pop
//   head         oldest buffered digit
//   count        number of buffered digits
//   full         count == PIN_LEN
module pin_buffer #(
  parameter int PIN_LEN = 4,
  parameter int CW      = $clog2(PIN_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [3:0]    push_digit,
  input  logic          pop,
  input  logic          clear,
  output logic [3:0]    head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [3:0]    slots_q [PIN_LEN];
  logic [3:0]    slots_d [PIN_LEN];
  logic [CW-1:0] count_q, count_d;

  // Slot 0 is always the oldest digit; popping shifts everything down.
  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (pop && (count_q != '0)) begin
      for (int i = 0; i < PIN_LEN; i++) begin
        if (i < PIN_LEN - 1) slots_d[i] = slots_q[i+1];
        else                 slots_d[i] = 4'h0;
      end
      count_d = count_q - CW'(1);
    end else if (push && (count_q != CW'(PIN_LEN))) begin
      for (int i = 0; i < PIN_LEN; i++) begin
        if (count_q == CW'(i)) slots_d[i] = push_digit;
      end
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < PIN_LEN; i++) slots_q[i] <= 4'h0;
    end else begin
      count_q <= count_d;
      slots_q <= slots_d;
    end
  end

  assign head  = slots_q[0];
  assign count = count_q;
  assign full  = (count_q == CW'(PIN_LEN));

endmodule

// File: rtl/keypad_tx.sv
// keypad_tx: collects keypad digits into a PIN buffer and, on ARM / DISARM /
// SET, sends one frame to the security controller: a command cycle followed
// by the buffered digits, oldest first, then a DONE cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   key_valid       key_code valid (scanner holds the key until key_ready)
//   key_code        0-9 digit, A ARM, B DISARM, C SET, D CLEAR, E/F ignored
//   key_ready       accepting keys (only in COLLECT, decoded from state)
//   command         00 NOP, 01 ARM, 10 DISARM, 11 SET (registered)
//   digit           PIN digit, valid with input_digit (registered)
//   input_digit     digit strobe (registered)
//   entry_count     digits currently buffered
//   key_drop        pulse: accepted key rejected
//   frame_done      pulse: frame complete
//   entry_timeout   pulse: partial entry discarded by the idle timeout
// Build option: SECURITY_KEYPAD_TIMEOUT_EN adds the idle timeout counter;
// without it entry_timeout is tied 0 and partial entries persist.
// Handshake: a key transfers on a rising edge where key_valid && key_ready;
// key_valid without key_ready transfers nothing and has no side effects.
module keypad_tx
  import security_pkg::*;
#(
  parameter int PIN_LEN = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  output logic                         key_ready,
  output logic [1:0]                   command,
  output logic [3:0]                   digit,
  output logic                         input_digit,
  output logic [$clog2(PIN_LEN+1)-1:0] entry_count,
  output logic                         key_drop,
  output logic                         frame_done,
  output logic                         entry_timeout
);

  localparam int CW = $clog2(PIN_LEN + 1);

  // Out-of-range parameters elaborate this empty block, which makes them
  // easy to spot in an elaborated hierarchy.
  if (PIN_LEN < 1 || PIN_LEN > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_illegal_params
  end

  kp_state_e     state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [1:0]    command_q, command_d;
  logic [3:0]    digit_q, digit_d;
  logic          input_digit_q, input_digit_d;
  logic          key_drop_q, key_drop_d;
  logic          frame_done_q, frame_done_d;
  logic          entry_timeout_q, entry_timeout_d;

  logic          accept, is_digit, is_cmd, cmd_go;
  logic          buf_push, buf_pop, buf_clear, buf_full;
  logic [3:0]    buf_head;
  logic [CW-1:0] buf_count;
  logic          tmo_fire;

  assign key_ready = (state_q == ST_COLLECT);
  assign accept    = key_valid && key_ready;
  assign is_digit  = (key_code <= 4'd9);
  assign is_cmd    = (key_code == KEY_ARM) || (key_code == KEY_DISARM) ||
                     (key_code == KEY_SET);
  assign cmd_go    = accept && is_cmd && buf_full;

  pin_buffer #(.PIN_LEN(PIN_LEN), .CW(CW)) u_pin_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_digit (key_code),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .head       (buf_head),
    .count      (buf_count),
    .full       (buf_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // Next state. DIGITS pops one digit per cycle (the first pop happens on
  // the way in from CMD), so an empty buffer means the last digit is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (cmd_go) state_d = ST_CMD;
      ST_CMD:     state_d = ST_DIGITS;
      ST_DIGITS:  if (buf_count == '0) state_d = ST_DONE;
      ST_DONE:    state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    command_d       = CMD_NOP;
    input_digit_d   = 1'b0;
    digit_d         = 4'h0;
    frame_done_d    = 1'b0;
    entry_timeout_d = tmo_fire;
    key_drop_d      = accept && ((is_digit && buf_full) || (is_cmd && !buf_full));
    if (state_d == ST_CMD || state_d == ST_DIGITS) command_d = cmd_d;
    if (state_d == ST_DIGITS) begin
      input_digit_d = 1'b1;
      digit_d       = buf_head;
    end
    if (state_d == ST_DONE) frame_done_d = 1'b1;
  end

  // Buffer control and command latch.
  always_comb begin
    cmd_d     = cmd_q;
    buf_push  = accept && is_digit && !buf_full;
    buf_pop   = (state_d == ST_DIGITS);
    buf_clear = (accept && ((key_code == KEY_CLEAR) || (is_cmd && !buf_full))) ||
                (state_q == ST_DONE) || tmo_fire;
    if (cmd_go) cmd_d = key_to_cmd(key_code);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q           <= CMD_NOP;
      command_q       <= CMD_NOP;
      digit_q         <= 4'h0;
      input_digit_q   <= 1'b0;
      key_drop_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      entry_timeout_q <= 1'b0;
    end else begin
      cmd_q           <= cmd_d;
      command_q       <= command_d;
      digit_q         <= digit_d;
      input_digit_q   <= input_digit_d;
      key_drop_q      <= key_drop_d;
      frame_done_q    <= frame_done_d;
      entry_timeout_q <= entry_timeout_d;
    end
  end

`ifdef SECURITY_KEYPAD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Counts idle cycles of a partial entry. An accepted key in the cycle the
  // count would reach TIMEOUT suppresses the timeout and restarts counting.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_fire  = 1'b0;
    if (!accept && state_q == ST_COLLECT && buf_count != '0) begin
      if (tmo_cnt_q == TMO_LAST) tmo_fire  = 1'b1;
      else                       tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign command       = command_q;
  assign digit         = digit_q;
  assign input_digit   = input_digit_q;
  assign entry_count   = buf_count;
  assign key_drop      = key_drop_q;
  assign frame_done    = frame_done_q;
  assign entry_timeout = entry_timeout_q;

endmodule

// File: tb/tb_keypad_tx.sv
// Testbench for keypad_tx. Reference model: a queue of buffered digits
// updated from the key rules; frames are predicted from a snapshot of it.
module tb_keypad_tx;

  localparam int PIN_LEN = 4;
  localparam int TIMEOUT = 10;
  localparam int CW      = $clog2(PIN_LEN + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          key_ready;
  logic [1:0]    command;
  logic [3:0]    digit;
  logic          input_digit;
  logic [CW-1:0] entry_count;
  logic          key_drop;
  logic          frame_done;
  logic          entry_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [3:0] pin_q[$];
  logic [3:0] exp_q[$];
  logic       m_drop;
  logic       m_frame;
  logic [1:0] m_cmd;

  keypad_tx #(.PIN_LEN(PIN_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ready     (key_ready),
    .command       (command),
    .digit         (digit),
    .input_digit   (input_digit),
    .entry_count   (entry_count),
    .key_drop      (key_drop),
    .frame_done    (frame_done),
    .entry_timeout (entry_timeout)
  );

  always #5 clk = ~clk;

  // Presents key k, waits (bounded) for acceptance and returns at the
  // falling edge after the accepting edge with key_valid low. Updates the
  // model and leaves the prediction in m_drop / m_frame / m_cmd / exp_q.
  task automatic press(input logic [3:0] k);
    int guard;
    guard = 0;
    key_valid = 1'b1;
    key_code  = k;
    while (key_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL press_wait key=%h key_ready=%b required 1", k, key_ready);
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    m_drop = 1'b0; m_frame = 1'b0; m_cmd = 2'b00;
    if (k <= 4'd9) begin
      if (pin_q.size() < PIN_LEN) pin_q.push_back(k);
      else m_drop = 1'b1;
    end else if (k == 4'hD) begin
      pin_q.delete();
    end else if (k >= 4'hA && k <= 4'hC) begin
      if (pin_q.size() == PIN_LEN) begin
        m_frame = 1'b1;
        m_cmd = (k == 4'hA) ? 2'b01 : (k == 4'hB) ? 2'b10 : 2'b11;
        exp_q = pin_q;
      end else begin
        m_drop = 1'b1;
      end
      pin_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || command !== 2'b00 || digit !== 4'h0 || input_digit !== 1'b0 ||
        entry_count !== '0 || key_drop !== 1'b0 || frame_done !== 1'b0 || entry_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values rdy=%b cmd=%b dig=%h id=%b cnt=%0d drop=%b fd=%b to=%b required rdy=1 rest 0",
               key_ready, command, digit, input_digit, entry_count, key_drop, frame_done, entry_timeout);
    end
    reset = 1'b0;
    pin_q.delete();
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || entry_count !== '0 || command !== 2'b00) begin
      errors++;
      $display("FAIL after_reset rdy=%b cnt=%0d cmd=%b required 1 0 00", key_ready, entry_count, command);
    end
  endtask

  task automatic test_arm_frame;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++;
    if (entry_count !== CW'(4)) begin
      errors++; $display("FAIL arm_fill count=%0d required 4", entry_count);
    end
    press(4'hA);
    checks++;
    if (command !== 2'b01 || input_digit !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL arm_cmd cmd=%b id=%b rdy=%b required 01 0 0", command, input_digit, key_ready);
    end
    for (int i = 0; i < PIN_LEN; i++) begin
      @(negedge clk);
      checks++;
      if (command !== 2'b01 || input_digit !== 1'b1 || digit !== exp_q[i]) begin
        errors++;
        $display("FAIL arm_digit%0d cmd=%b id=%b dig=%h required 01 1 %h", i, command, input_digit, digit, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || command !== 2'b00 || input_digit !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL arm_done fd=%b cmd=%b id=%b rdy=%b required 1 00 0 0", frame_done, command, input_digit, key_ready);
    end
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || entry_count !== '0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL arm_after rdy=%b cnt=%0d fd=%b required 1 0 0", key_ready, entry_count, frame_done);
    end
  endtask

  task automatic test_short_cmd;
    press(4'd5); press(4'd5);
    press(4'hB);
    checks++;
    if (key_drop !== 1'b1 || command !== 2'b00 || entry_count !== '0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL short_cmd drop=%b cmd=%b cnt=%0d rdy=%b required 1 00 0 1", key_drop, command, entry_count, key_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (key_drop !== 1'b0 || command !== 2'b00 || input_digit !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL short_idle drop=%b cmd=%b id=%b fd=%b required 0", key_drop, command, input_digit, frame_done);
      end
    end
  endtask

  task automatic test_overflow;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd9);
    checks++;
    if (key_drop !== 1'b1 || entry_count !== CW'(4)) begin
      errors++; $display("FAIL overflow_drop drop=%b cnt=%0d required 1 4", key_drop, entry_count);
    end
    press(4'hC);
    checks++;
    if (command !== 2'b11 || input_digit !== 1'b0 || key_drop !== 1'b0) begin
      errors++; $display("FAIL set_cmd cmd=%b id=%b drop=%b required 11 0 0", command, input_digit, key_drop);
    end
    for (int i = 0; i < PIN_LEN; i++) begin
      @(negedge clk);
      checks++;
      if (command !== 2'b11 || input_digit !== 1'b1 || digit !== exp_q[i]) begin
        errors++; $display("FAIL set_digit%0d cmd=%b id=%b dig=%h required 11 1 %h", i, command, input_digit, digit, exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL set_done fd=%b required 1", frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_during_frame;
    press(4'd6); press(4'd7); press(4'd8); press(4'd0);
    press(4'hA);
    key_valid = 1'b1;
    key_code  = 4'd7;
    for (int i = 2; i <= PIN_LEN + 2; i++) begin
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b0 || key_drop !== 1'b0 || frame_done !== (i == PIN_LEN + 2)) begin
        errors++; $display("FAIL hold_cycle%0d rdy=%b drop=%b fd=%b required 0 0 %0d", i, key_ready, key_drop, frame_done, i == PIN_LEN + 2);
      end
    end
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || entry_count !== '0) begin
      errors++; $display("FAIL hold_ready rdy=%b cnt=%0d required 1 0", key_ready, entry_count);
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    pin_q.delete();
    pin_q.push_back(4'd7);
    checks++;
    if (entry_count !== CW'(pin_q.size()) || key_drop !== 1'b0) begin
      errors++; $display("FAIL hold_accept cnt=%0d drop=%b required %0d 0", entry_count, key_drop, pin_q.size());
    end
    press(4'hD);
  endtask

  task automatic test_reset_mid_frame;
    press(4'd2); press(4'd4); press(4'd6); press(4'd8);
    press(4'hB);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (input_digit !== 1'b1 || digit !== exp_q[1]) begin
      errors++; $display("FAIL midrst_digit2 id=%b dig=%h required 1 %h", input_digit, digit, exp_q[1]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pin_q.delete();
    checks++;
    if (key_ready !== 1'b1 || command !== 2'b00 || digit !== 4'h0 || input_digit !== 1'b0 ||
        entry_count !== '0 || key_drop !== 1'b0 || frame_done !== 1'b0 || entry_timeout !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs rdy=%b cmd=%b dig=%h id=%b cnt=%0d fd=%b required rdy=1 rest 0",
                         key_ready, command, digit, input_digit, entry_count, frame_done);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || input_digit !== 1'b0 || command !== 2'b00) begin
        errors++; $display("FAIL midrst_quiet fd=%b id=%b cmd=%b required 0 0 00", frame_done, input_digit, command);
      end
    end
  endtask

  task automatic test_timeout;
    press(4'd3);
`ifdef SECURITY_KEYPAD_TIMEOUT_EN
    // Sample i is the falling edge after i-1 idle cycles; the pulse shows
    // once TIMEOUT idle cycles have elapsed.
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if (entry_timeout !== (i == TIMEOUT + 1)) begin
        errors++; $display("FAIL timeout_pulse sample%0d to=%b required %0d", i, entry_timeout, i == TIMEOUT + 1);
      end
      if (i == TIMEOUT + 1) begin
        pin_q.delete();
        checks++;
        if (entry_count !== '0) begin
          errors++; $display("FAIL timeout_count cnt=%0d required 0", entry_count);
        end
      end
    end
`else
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      @(negedge clk);
      checks++;
      if (entry_timeout !== 1'b0 || entry_count !== CW'(1)) begin
        errors++; $display("FAIL no_timeout to=%b cnt=%0d required 0 1", entry_timeout, entry_count);
      end
    end
`endif
    press(4'hD);
  endtask

  task automatic test_random;
    int r;
    logic [3:0] k;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12 || r > 17) k = 4'($urandom_range(0, 9));
      else                  k = 4'(r - 2);
      press(k);
      if (m_frame) begin
        checks++;
        if (command !== m_cmd || input_digit !== 1'b0) begin
          errors++; $display("FAIL rnd_cmd cmd=%b id=%b required %b 0", command, input_digit, m_cmd);
        end
        for (int i = 0; i < PIN_LEN; i++) begin
          @(negedge clk);
          checks++;
          if (command !== m_cmd || input_digit !== 1'b1 || digit !== exp_q[i]) begin
            errors++; $display("FAIL rnd_digit%0d cmd=%b id=%b dig=%h required %b 1 %h", i, command, input_digit, digit, m_cmd, exp_q[i]);
          end
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || command !== 2'b00 || input_digit !== 1'b0) begin
          errors++; $display("FAIL rnd_done fd=%b cmd=%b id=%b required 1 00 0", frame_done, command, input_digit);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || entry_count !== '0) begin
          errors++; $display("FAIL rnd_after rdy=%b cnt=%0d required 1 0", key_ready, entry_count);
        end
      end else begin
        checks++;
        if (key_drop !== m_drop || entry_count !== CW'(pin_q.size()) ||
            command !== 2'b00 || input_digit !== 1'b0 || frame_done !== 1'b0) begin
          errors++; $display("FAIL rnd_key k=%h drop=%b cnt=%0d cmd=%b id=%b fd=%b required %b %0d 00 0 0",
                             k, key_drop, entry_count, command, input_digit, frame_done, m_drop, pin_q.size());
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arm_frame();
    test_short_cmd();
    test_overflow();
    test_hold_during_frame();
    test_reset_mid_frame();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
